pipelined_cla_addsub: RTL and testbench
=======================================

Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the integer datapath.
- Splits a WIDTH-bit operation into SEG-bit lookahead segments, one segment per pipeline stage, with the carry registered between stages.
- Adds subtract mode, status flags (carry, signed overflow, zero, negative) and a valid/ready handshake with backpressure.
- Sits between operand select and writeback; replaces single-cycle fixed-width adders on timing-critical paths.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG.
- SEG, 8, segment width handled by one lookahead block per stage.
- STAGES (derived localparam), WIDTH/SEG, pipeline depth and latency in cycles.

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  1 = A-B, 0 = A+B
- cin  input  1  carry-in, add mode only
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB; in sub mode 1 = no borrow
- ovf  output  1  signed two's-complement overflow of the raw result
- zero  output  1  sum == 0
- neg  output  1  sum[WIDTH-1]

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid bits 0; sum, cout, ovf, zero and neg are 0; out_valid is 0.
- Arithmetic:
  - Effective B is b XOR {WIDTH{sub}}.
  - Effective carry-in is sub ? 1 : cin; cin is ignored when sub=1.
  - Stage k computes bits [k*SEG +: SEG] using per-bit generate (a&b) and propagate (a|b) lookahead, taking the registered carry from stage k-1.
  - Upper operand bits are skewed forward through the stages unchanged.
  - Lower result bits are delayed so that all WIDTH bits emerge together.
- Flags, computed in the final stage:
  - ovf = carry into MSB XOR carry out of MSB.
  - zero and neg are computed on the final sum.
- Latency: exactly STAGES cycles from the accept edge (in_valid && in_ready) to out_valid, assuming no stall.
- Throughput: one beat per cycle.
- Stall:
  - advance = out_ready || !out_valid; in_ready = advance.
  - When advance=0, every stage register, valid bits included, holds its value.
  - Bubbles are not collapsed.
- Output hold: while out_valid && !out_ready, sum and all flags are stable.
- A beat presented with in_valid=1 and in_ready=0 is not consumed; the source holds it.
- Simultaneous accept and output-consume in the same cycle is legal and loses no beat.
- Reset mid-operation: all in-flight beats are discarded; no output appears for them after reset.
- SEG == WIDTH: single stage, latency 1.
- WIDTH % SEG != 0: elaboration-time error.

Optional Feature:
- Macro: ADDER_SATURATE_EN.
- Defined:
  - Adds input port sat_mode (1 bit), sampled with the operands.
  - When sat_mode=1 and raw overflow occurs, sum clamps to the signed max (0x7FF..F) if the raw result was negative, otherwise to the signed min (0x80..0).
  - ovf still reports the raw overflow.
  - zero and neg reflect the clamped sum.
  - cout is unchanged.
- Undefined: no sat_mode port; the raw result is always output.

Decomposition:
- Package adder_pkg:
  - Default SEG constant.
  - Flags struct {cout, ovf, zero, neg}.
  - Function computing the segment count.
- One sub-module, cla_segment:
  - Combinational SEG-bit lookahead: inputs a, b, cin; outputs s, cout, plus the carry into its MSB for overflow detection.
  - Instantiated once per stage via generate.

Test Plan (WIDTH=32, SEG=8, latency 4):
- 0x000000FF + 0x00000001, cin=0 -> 4 cycles later sum=0x00000100, cout=0, ovf=0, zero=0, neg=0 (carry crosses stage boundary).
- 0xFFFFFFFF + 0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0, zero=1 (carry ripples through all 4 stages).
- sub=1: 0x7FFFFFFF - 0xFFFFFFFF -> sum=0x80000000, ovf=1, neg=1, cout=0; and 5 - 5 -> sum=0, zero=1, cout=1.
- 8 back-to-back beats with out_ready toggling 1,0,1,0 -> results arrive in order with none lost or duplicated; in_ready low exactly when out_valid && !out_ready; outputs stable during stall.
- 3 beats in flight, rstn pulsed low one cycle -> out_valid=0 and all outputs 0 during reset; no output for the discarded beats afterwards; a new beat completes 4 cycles after accept.
- ADDER_SATURATE_EN, sat_mode=1: 0x7FFFFFFF + 1 -> sum=0x7FFFFFFF, ovf=1, neg=0; 0x80000000 - 1 -> sum=0x80000000, ovf=1, neg=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants, flag bundle and sizing helper for the pipelined CLA adder/subtractor.
package adder_pkg;

  localparam int SEG_DEFAULT = 8;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  function automatic int seg_count(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-lookahead block; also exposes the carry into its MSB
// so the last segment can detect signed overflow.
module cla_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_s,
  output logic           o_cout,
  output logic           o_cmsb
);

  logic [SEG-1:0] w_g;
  logic [SEG-1:0] w_p;
  logic [SEG:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a | i_b;

  // Every carry is a flat sum-of-products of generate/propagate terms, no ripple chain.
  always_comb begin
    logic v_any;
    logic v_prop;
    v_any  = 1'b0;
    v_prop = 1'b0;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < SEG; i++) begin
      v_any = w_g[i];
      for (int j = 0; j < i; j++) begin
        v_prop = 1'b1;
        for (int m = j + 1; m <= i; m++) v_prop = v_prop & w_p[m];
        v_any = v_any | (w_g[j] & v_prop);
      end
      v_prop = i_cin;
      for (int m = 0; m <= i; m++) v_prop = v_prop & w_p[m];
      w_c[i+1] = v_any | v_prop;
    end
  end

  assign o_s    = i_a ^ i_b ^ w_c[SEG-1:0];
  assign o_cout = w_c[SEG];
  assign o_cmsb = w_c[SEG-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead add/sub, one SEG-bit segment per stage, valid/ready with stall.
// Optional saturation enabled by defining ADDER_SATURATE_EN (adds the sat_mode port).
module pipelined_cla_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = SEG_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
`ifdef ADDER_SATURATE_EN
  input  logic             sat_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = seg_count(WIDTH, SEG);
  localparam int NREG   = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % SEG) != 0) begin : g_bad_width
    $error("pipelined_cla_addsub: WIDTH must be a multiple of SEG");
  end

  // Stage inputs (combinational) and stage outputs
  logic [WIDTH-1:0] w_ain  [STAGES];
  logic [WIDTH-1:0] w_bin  [STAGES];
  logic [WIDTH-1:0] w_sin  [STAGES];
  logic             w_cin  [STAGES];
  logic [WIDTH-1:0] w_sout [STAGES];
  logic             w_cout [STAGES];
  logic             w_cmsb [STAGES];

  // Inter-stage registers: skewed operands, partial sum and segment carry
  logic [WIDTH-1:0] r_a [NREG];
  logic [WIDTH-1:0] r_b [NREG];
  logic [WIDTH-1:0] r_s [NREG];
  logic             r_c [NREG];
  logic [STAGES-1:0] r_vld;

`ifdef ADDER_SATURATE_EN
  logic w_satin [STAGES];
  logic r_sat   [NREG];
`endif

  logic             w_adv;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  flags_t           w_flags;
  logic [WIDTH-1:0] r_sum;
  flags_t           r_flags;

`ifdef ADDER_SATURATE_EN
  function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] raw,
                                                 input logic raw_ovf,
                                                 input logic en);
    logic [WIDTH-1:0] v_max;
    v_max = {1'b0, {(WIDTH-1){1'b1}}};
    if (en && raw_ovf)
      return raw[WIDTH-1] ? v_max : ~v_max;
    return raw;
  endfunction
`endif

  assign w_adv    = out_ready || !r_vld[LAST];
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    logic [SEG-1:0] w_seg_s;

    if (k == 0) begin : g_in
      assign w_ain[0] = a;
      assign w_bin[0] = b ^ {WIDTH{sub}};
      assign w_sin[0] = '0;
      assign w_cin[0] = sub | cin;
`ifdef ADDER_SATURATE_EN
      assign w_satin[0] = sat_mode;
`endif
    end else begin : g_fwd
      assign w_ain[k] = r_a[k-1];
      assign w_bin[k] = r_b[k-1];
      assign w_sin[k] = r_s[k-1];
      assign w_cin[k] = r_c[k-1];
`ifdef ADDER_SATURATE_EN
      assign w_satin[k] = r_sat[k-1];
`endif
    end

    cla_segment #(.SEG(SEG)) u_seg (
      .i_a   (w_ain[k][LO +: SEG]),
      .i_b   (w_bin[k][LO +: SEG]),
      .i_cin (w_cin[k]),
      .o_s   (w_seg_s),
      .o_cout(w_cout[k]),
      .o_cmsb(w_cmsb[k])
    );

    // Bits above this segment are still zero in the partial sum, so OR-in is exact.
    assign w_sout[k] = w_sin[k] | (WIDTH'(w_seg_s) << LO);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) r_vld[k] <= r_vld[k-1];
    end
  end

  // Stage k -> stage k+1 boundary
  if (STAGES > 1) begin : g_pipe
    always_ff @(posedge clk) begin
      if (w_adv) begin
        for (int k = 0; k < STAGES - 1; k++) begin
          r_a[k] <= w_ain[k];
          r_b[k] <= w_bin[k];
          r_s[k] <= w_sout[k];
          r_c[k] <= w_cout[k];
`ifdef ADDER_SATURATE_EN
          r_sat[k] <= w_satin[k];
`endif
        end
      end
    end
  end

  assign w_ovf = w_cmsb[LAST] ^ w_cout[LAST];

  always_comb begin
`ifdef ADDER_SATURATE_EN
    w_res = sat_clamp(w_sout[LAST], w_ovf, w_satin[LAST]);
`else
    w_res = w_sout[LAST];
`endif
    w_flags      = '0;
    w_flags.cout = w_cout[LAST];
    w_flags.ovf  = w_ovf;
    w_flags.zero = (w_res == '0);
    w_flags.neg  = w_res[WIDTH-1];
  end

  // Final stage -> output register boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sum   <= '0;
      r_flags <= '0;
    end else if (w_adv) begin
      r_sum   <= w_res;
      r_flags <= w_flags;
    end
  end

  assign out_valid = r_vld[LAST];
  assign sum       = r_sum;
  assign cout      = r_flags.cout;
  assign ovf       = r_flags.ovf;
  assign zero      = r_flags.zero;
  assign neg       = r_flags.neg;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub (WIDTH=32, SEG=8); honours ADDER_SATURATE_EN.
module tb_pipelined_cla_addsub;

  localparam int WIDTH = 32;
  localparam int SEG   = 8;
  localparam int LAT   = WIDTH / SEG;
  localparam int NRAND = 150;
`ifdef ADDER_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        cin;
`ifdef ADDER_SATURATE_EN
  logic        sat_mode;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic [3:0]  flags;
  } res_t;

  pipelined_cla_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .cin      (cin),
`ifdef ADDER_SATURATE_EN
    .sat_mode (sat_mode),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero),
    .neg      (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, then range test for overflow.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input logic ci, input logic sm);
    longint          sx, sy, r;
    longint unsigned ux, uy;
    logic [31:0]     raw;
    logic            c, o;
    res_t            e;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    if (s) begin
      r   = sx - sy;
      c   = (ux >= uy);
      raw = x - y;
    end else begin
      r   = sx + sy + longint'(ci);
      c   = ((ux + uy + longint'(ci)) >> 32) != 0;
      raw = x + y + 32'(ci);
    end
    o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.sum = raw;
    if (sm && SAT_EN && o) e.sum = (r < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    e.flags = {c, o, (e.sum == 32'd0), e.sum[31]};
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
`ifdef ADDER_SATURATE_EN
    sat_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++;
    if (sum !== 32'd0) begin errors++; $display("FAIL reset_sum got %h want 0", sum); end
    checks++;
    if ({cout, ovf, zero, neg} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {cout, ovf, zero, neg});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [31:0] va [4] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5};
    logic [31:0] vb [4] = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'd5};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] es [4] = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
    logic [3:0]  ef [4] = '{4'b0000, 4'b1010, 4'b0101, 4'b1010};
    int lat;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i]; sub = vs[i]; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      checks++;
      if (lat !== LAT) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); end
      checks++;
      if (sum !== es[i]) begin errors++; $display("FAIL dir%0d_sum got %h want %h", i, sum, es[i]); end
      checks++;
      if ({cout, ovf, zero, neg} !== ef[i]) begin
        errors++; $display("FAIL dir%0d_flags got %b want %b", i, {cout, ovf, zero, neg}, ef[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ba [8];
    logic [31:0] bb [8];
    logic        bs [8];
    logic        bc [8];
    res_t        e;
    int sent = 0, rcv = 0, cyc = 0;
    logic prev_stall = 1'b0;
    logic [35:0] held = '0;
    for (int i = 0; i < 8; i++) begin
      ba[i] = rand_op(); bb[i] = rand_op(); bs[i] = $urandom_range(0, 1); bc[i] = $urandom_range(0, 1);
    end
`ifdef ADDER_SATURATE_EN
    sat_mode = 1'b0;
`endif
    while ((sent < 8 || rcv < 8) && cyc < 200) begin
      if (prev_stall) begin
        checks++;
        if ({out_valid, sum, cout, ovf, zero, neg} !== {1'b1, held}) begin
          errors++; $display("FAIL b2b_hold got %b_%h want 1_%h", out_valid, {sum, cout, ovf, zero, neg}, held);
        end
      end
      out_ready = (cyc % 2) == 0;
      in_valid  = sent < 8;
      if (sent < 8) begin a = ba[sent]; b = bb[sent]; sub = bs[sent]; cin = bc[sent]; end
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL b2b_in_ready got %b want %b", in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        e = model(ba[rcv], bb[rcv], bs[rcv], bc[rcv], 1'b0);
        checks++;
        if ({sum, cout, ovf, zero, neg} !== {e.sum, e.flags}) begin
          errors++; $display("FAIL b2b_beat%0d got %h want %h", rcv, {sum, cout, ovf, zero, neg}, {e.sum, e.flags});
        end
        rcv++;
      end
      prev_stall = out_valid && !out_ready;
      held = {sum, cout, ovf, zero, neg};
      if (in_valid && in_ready) sent++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (sent != 8 || rcv != 8) begin errors++; $display("FAIL b2b_count got %0d/%0d want 8/8", sent, rcv); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_out got %b want 0", out_valid); end
    end
  endtask

  task automatic test_random;
    res_t q[$];
    res_t e;
    int sent = 0, cyc = 0;
    logic have = 1'b0, xs = 1'b0, xc = 1'b0, xm = 1'b0, prev_stall = 1'b0;
    logic [31:0] xa = '0, xb = '0;
    logic [35:0] held = '0;
    while ((sent < NRAND || q.size() != 0) && cyc < 5000) begin
      if (prev_stall) begin
        checks++;
        if ({out_valid, sum, cout, ovf, zero, neg} !== {1'b1, held}) begin
          errors++; $display("FAIL rnd_hold got %b_%h want 1_%h", out_valid, {sum, cout, ovf, zero, neg}, held);
        end
      end
      if (!have && sent < NRAND && $urandom_range(0, 3) != 0) begin
        xa = rand_op(); xb = rand_op(); xs = $urandom_range(0, 1); xc = $urandom_range(0, 1);
        xm = $urandom_range(0, 1); have = 1'b1;
      end
      in_valid = have; a = xa; b = xb; sub = xs; cin = xc;
`ifdef ADDER_SATURATE_EN
      sat_mode = xm;
`endif
      out_ready = $urandom_range(0, 2) != 0;
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL rnd_in_ready got %b want %b", in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected got %h want none", sum);
        end else begin
          e = q.pop_front();
          if ({sum, cout, ovf, zero, neg} !== {e.sum, e.flags}) begin
            errors++; $display("FAIL rnd_beat got %h want %h", {sum, cout, ovf, zero, neg}, {e.sum, e.flags});
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {sum, cout, ovf, zero, neg};
      if (in_valid && in_ready) begin
        q.push_back(model(xa, xb, xs, xc, xm));
        sent++;
        have = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (sent != NRAND || q.size() != 0) begin
      errors++; $display("FAIL rnd_drain got sent=%0d pending=%0d want %0d/0", sent, q.size(), NRAND);
    end
  endtask

  task automatic test_reset_midflight;
    int lat;
    out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
`ifdef ADDER_SATURATE_EN
    sat_mode = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      a = 32'hFFFF_FFFF; b = 32'(i + 1); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if ({out_valid, sum, cout, ovf, zero, neg} !== 37'd0) begin
      errors++; $display("FAIL rst_mid_outputs got %h want 0", {out_valid, sum, cout, ovf, zero, neg});
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ghost got %b want 0", out_valid); end
    end
    a = 32'h1234_5678; b = 32'h1111_1111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL rst_mid_latency got %0d want %0d", lat, LAT); end
    checks++;
    if (sum !== 32'h2345_6789) begin errors++; $display("FAIL rst_mid_sum got %h want 23456789", sum); end
    @(negedge clk);
  endtask

`ifdef ADDER_SATURATE_EN
  task automatic test_saturate;
    logic [31:0] va [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
    logic        vs [2] = '{1'b0, 1'b1};
    logic [31:0] es [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
    logic [3:0]  ef [2] = '{4'b0100, 4'b1101};
    int lat;
    for (int i = 0; i < 2; i++) begin
      a = va[i]; b = 32'd1; sub = vs[i]; cin = 1'b0; sat_mode = 1'b1;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; sat_mode = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      checks++;
      if (sum !== es[i]) begin errors++; $display("FAIL sat%0d_sum got %h want %h", i, sum, es[i]); end
      checks++;
      if ({cout, ovf, zero, neg} !== ef[i]) begin
        errors++; $display("FAIL sat%0d_flags got %b want %b", i, {cout, ovf, zero, neg}, ef[i]);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
`ifdef ADDER_SATURATE_EN
    test_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
